// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state synchronous memory.
package mem_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Wait-state counter width covers WAIT_STATES up to 15.
  localparam int unsigned CNT_W = 4;

  // Geometry of the boot image.
  localparam int unsigned BOOT_DEPTH = 16;
  localparam int unsigned BOOT_W     = 8;
  localparam int unsigned BOOT_IDX_W = 4;

  // Program words loaded at power-up for the default 16 x 8 geometry.
  localparam logic [BOOT_W-1:0] BOOT_IMAGE [BOOT_DEPTH] = '{
    8'h4C, 8'h5A, 8'h7A, 8'h3F, 8'h11, 8'h22, 8'h96, 8'hC3,
    8'hE1, 8'h0D, 8'h08, 8'hB7, 8'h64, 8'h29, 8'hF0, 8'h81
  };

endpackage

// File: rtl/sync_memory_if.sv
// Request/response bundle between a requester and sync_memory.
interface sync_memory_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;

  // Requester side.
  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err, busy
  );

  // Memory side.
  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err, busy
  );

endinterface

// File: rtl/mem_array.sv
// Single-port storage with write enable and registered read data.
// The read register returns zero on any cycle without a read access.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [DATA_W-1:0] word_arr_t [DEPTH];

  // Power-up contents: boot image for the default geometry, zeros otherwise.
  function automatic word_arr_t boot_contents();
    word_arr_t img;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (DEPTH == BOOT_DEPTH && DATA_W == BOOT_W) begin
        img[IDX_W'(i)] = DATA_W'(BOOT_IMAGE[BOOT_IDX_W'(i)]);
      end else begin
        img[IDX_W'(i)] = '0;
      end
    end
    return img;
  endfunction

  word_arr_t         mem_q = boot_contents();
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  assign idx_c = IDX_W'(addr);
  assign rdata = rdata_q;

  // Array write; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[idx_c] <= wdata;
    end
  end

  // Read data only on a read access, otherwise zero.
  always_comb begin
    rdata_d = '0;
    if (en && !we) begin
      rdata_d = mem_q[idx_c];
    end
  end

  // Read data register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: rtl/sync_memory.sv
// Wait-state memory: accepts a request in IDLE, counts WAIT_STATES cycles,
// performs the array access on the edge entering RESP and pulses ack there.
module sync_memory
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic          clk,
  input  logic          rst,
  sync_memory_if.slave  bus
);

  // Counter load value on acceptance; unused when there are no wait states.
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              access_c;
  logic              in_range_c;
  logic              mem_en_c;
  logic [DATA_W-1:0] mem_rdata;

  // State, counter, latched request and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, wait counter and request capture; inputs ignored when not IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Access strobe and next values of ack/err/busy; the _d request fields
  // already hold the live bus values when a zero-wait request is accepted.
  always_comb begin
    access_c   = (state_d == RESP);
    in_range_c = (32'(addr_d) < 32'(DEPTH));
    mem_en_c   = access_c && in_range_c;
    ack_d      = access_c;
    err_d      = access_c && !in_range_c;
    busy_d     = (state_d != IDLE);
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en_c),
    .we    (we_d),
    .addr  (addr_d),
    .wdata (wdata_d),
    .rdata (mem_rdata)
  );

  assign bus.rdata = mem_rdata;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_sync_memory.sv
// Bench for sync_memory: three configurations (default, DEPTH=12, zero wait
// states) driven with directed and random accesses against an array model.
module tb_sync_memory;

  localparam logic [7:0] BOOT_REF [16] = '{
    8'h4C, 8'h5A, 8'h7A, 8'h3F, 8'h11, 8'h22, 8'h96, 8'hC3,
    8'hE1, 8'h0D, 8'h08, 8'hB7, 8'h64, 8'h29, 8'hF0, 8'h81
  };
  localparam int DEPTHS [3] = '{16, 12, 16};
  localparam int WSTATE [3] = '{2, 2, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] model [3][16];

  always #5 clk = ~clk;

  sync_memory_if #(.DATA_W(8), .ADDR_W(4)) if_a ();
  sync_memory_if #(.DATA_W(8), .ADDR_W(4)) if_b ();
  sync_memory_if #(.DATA_W(8), .ADDR_W(4)) if_c ();

  sync_memory #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .WAIT_STATES(2)) u_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  sync_memory #(.DATA_W(8), .DEPTH(12), .ADDR_W(4), .WAIT_STATES(2)) u_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );
  sync_memory #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .WAIT_STATES(0)) u_c (
    .clk(clk), .rst(rst), .bus(if_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [3:0] a, input logic [7:0] d);
    case (sel)
      0:       begin if_a.req = r; if_a.we = w; if_a.addr = a; if_a.wdata = d; end
      1:       begin if_b.req = r; if_b.we = w; if_b.addr = a; if_b.wdata = d; end
      default: begin if_c.req = r; if_c.we = w; if_c.addr = a; if_c.wdata = d; end
    endcase
  endtask

  // {busy, ack, err, rdata}
  function automatic logic [10:0] sample(input int sel);
    case (sel)
      0:       return {if_a.busy, if_a.ack, if_a.err, if_a.rdata};
      1:       return {if_b.busy, if_b.ack, if_b.err, if_b.rdata};
      default: return {if_c.busy, if_c.ack, if_c.err, if_c.rdata};
    endcase
  endfunction

  // One request; reports response fields, cycles to ack and busy cycles.
  task automatic access(input int sel, input logic w, input logic [3:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic er, output int lat, output int bcyc);
    logic [10:0] s;
    int n_ack;
    rd = '0; er = 1'b0; lat = 0; bcyc = 0; n_ack = 0;
    @(negedge clk); drive(sel, 1'b1, w, a, d);
    @(posedge clk);
    @(negedge clk); drive(sel, 1'b0, 1'b0, 4'd0, 8'd0);
    for (int k = 1; k <= 40; k++) begin
      s = sample(sel);
      if (s[10]) bcyc++;
      if (s[9]) begin
        n_ack++;
        if (n_ack == 1) begin lat = k; rd = s[7:0]; er = s[8]; end
      end else begin
        check("quiet_without_ack", 32'(s[8:0]), 32'd0);
      end
      if (n_ack > 0 && !s[10]) break;
      @(negedge clk);
    end
    check("ack_count", n_ack, 1);
  endtask

  // Access compared against the array model, which it also updates.
  task automatic run_and_check(input string tag, input int sel, input logic w,
                               input logic [3:0] a, input logic [7:0] d,
                               output logic [7:0] rd, output logic er);
    int lat, bc;
    logic [7:0] exp_rd;
    logic exp_er;
    if (int'(a) >= DEPTHS[sel]) begin
      exp_rd = 8'd0; exp_er = 1'b1;
    end else begin
      exp_er = 1'b0;
      if (w) begin exp_rd = 8'd0; model[sel][a] = d; end
      else   exp_rd = model[sel][a];
    end
    access(sel, w, a, d, rd, er, lat, bc);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, er, exp_er);
    check({tag, "_latency"}, lat, WSTATE[sel] + 1);
    check({tag, "_busy_cycles"}, bc, WSTATE[sel] + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic er;
    logic [10:0] s;
    int nack;
    logic w;
    logic [3:0] a;
    logic [7:0] d;

    for (int i = 0; i < 16; i++) begin
      model[0][i] = BOOT_REF[i];
      model[1][i] = 8'd0;
      model[2][i] = BOOT_REF[i];
    end
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 4'd0, 8'd0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      s = sample(i);
      check("reset_state", s, 11'd0);
    end
    rst = 1'b0;

    // Boot-image read with two wait states.
    run_and_check("boot_read", 0, 1'b0, 4'd0, 8'd0, rd, er);
    check("boot_read_literal", rd, 8'h4C);

    // Zero wait states.
    run_and_check("ws0_read", 2, 1'b0, 4'd10, 8'd0, rd, er);
    check("ws0_read_literal", rd, 8'h08);

    // Write then read back.
    run_and_check("wr5", 0, 1'b1, 4'd5, 8'hA5, rd, er);
    run_and_check("rd5", 0, 1'b0, 4'd5, 8'd0, rd, er);
    check("rd5_literal", rd, 8'hA5);

    // Out-of-range write on the 12-word instance, then contents unchanged.
    run_and_check("oor_wr13", 1, 1'b1, 4'd13, 8'hFF, rd, er);
    check("oor_err_literal", er, 1'b1);
    for (int i = 0; i < 12; i++) run_and_check("oor_scan", 1, 1'b0, 4'(i), 8'd0, rd, er);
    run_and_check("oor_rd13", 1, 1'b0, 4'd13, 8'd0, rd, er);

    // Request held while busy must be ignored.
    @(negedge clk); drive(0, 1'b1, 1'b0, 4'd3, 8'd0);
    @(posedge clk);
    @(negedge clk); drive(0, 1'b1, 1'b1, 4'd1, 8'h00);
    nack = 0; rd = 8'd0;
    for (int k = 1; k <= 20; k++) begin
      s = sample(0);
      if (s[9]) begin
        nack++;
        rd = s[7:0];
        drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
      end
      if (nack > 0 && !s[10]) break;
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    check("busy_req_ack_count", nack, 1);
    check("busy_req_first_rdata", rd, BOOT_REF[3]);
    repeat (3) @(negedge clk);
    s = sample(0);
    check("busy_req_no_second_access", s, 11'd0);
    run_and_check("rd1_after_ignored", 0, 1'b0, 4'd1, 8'd0, rd, er);
    check("rd1_literal", rd, 8'h5A);

    // Reset during WAIT aborts the write.
    @(negedge clk); drive(0, 1'b1, 1'b1, 4'd2, 8'h33);
    @(posedge clk);
    @(negedge clk); drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    s = sample(0);
    check("pre_reset_busy", s[10], 1'b1);
    rst = 1'b1;
    #1;
    s = sample(0);
    check("reset_async_outputs", s, 11'd0);
    nack = 0;
    repeat (4) begin
      @(negedge clk);
      s = sample(0);
      if (s[9]) nack++;
    end
    rst = 1'b0;
    check("reset_no_ack", nack, 0);
    run_and_check("rd2_after_abort", 0, 1'b0, 4'd2, 8'd0, rd, er);
    check("rd2_literal", rd, 8'h7A);
    run_and_check("rd5_after_reset", 0, 1'b0, 4'd5, 8'd0, rd, er);
    check("rd5_after_reset_literal", rd, 8'hA5);

    // Random traffic on all three instances.
    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom_range(0, 1)); a = 4'($urandom_range(0, 15)); d = 8'($urandom);
      run_and_check("rand_a", 0, w, a, d, rd, er);
    end
    for (int n = 0; n < 25; n++) begin
      w = 1'($urandom_range(0, 1)); a = 4'($urandom_range(0, 15)); d = 8'($urandom);
      run_and_check("rand_b", 1, w, a, d, rd, er);
    end
    for (int n = 0; n < 30; n++) begin
      w = 1'($urandom_range(0, 1)); a = 4'($urandom_range(0, 15)); d = 8'($urandom);
      run_and_check("rand_c", 2, w, a, d, rd, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_memory.md
SYNC_MEMORY -- requirements
Module: sync_memory

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, meaning word width in bits.
REQ-002 The block SHALL expose parameter DEPTH, default 16, meaning number of words; values need not be a power of two.
REQ-003 The block SHALL expose parameter ADDR_W, default 4, meaning address width; legal only if 2**ADDR_W >= DEPTH.
REQ-004 The block SHALL expose parameter WAIT_STATES, default 2, meaning extra access cycles (0..15).
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req  input  1  access request, sampled only in IDLE.
REQ-008 we  input  1  1 = write, 0 = read; qualified by req.
REQ-009 addr  input  ADDR_W  word address; qualified by req.
REQ-010 wdata  input  DATA_W  write data; qualified by req.
REQ-011 rdata  output  DATA_W  registered read data, valid only while ack=1.
REQ-012 ack  output  1  one-cycle completion pulse.
REQ-013 err  output  1  address out of range (addr >= DEPTH), valid only while ack=1.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-016 In IDLE with req=1 at edge E0, the block SHALL latch we, addr and wdata; the next state is WAIT with counter = WAIT_STATES-1 if WAIT_STATES>0, else RESP.
REQ-017 In WAIT, the counter SHALL decrement each edge; at the edge where it equals 0, the next state is RESP.
REQ-018 The memory access (array write, or read into rdata) SHALL occur at the edge entering RESP, i.e. edge E0+WAIT_STATES.
REQ-019 ack SHALL be 1 exactly during RESP, one cycle; RESP SHALL always return to IDLE at the next edge.
REQ-020 req, we, addr and wdata SHALL be ignored while busy=1; a request is accepted at most once every WAIT_STATES+2 cycles.
REQ-021 A write SHALL hold rdata at 0 during ack.
REQ-022 For addr >= DEPTH, the block SHALL not modify the array, SHALL drive rdata to 0 and SHALL drive err to 1 during ack; otherwise err is 0.
REQ-023 rdata and err SHALL be 0 whenever ack=0.
REQ-024 Writes SHALL be full-word; no partial writes.

Reset
REQ-025 While rst=1, the block SHALL force state=IDLE, counter=0, rdata=0, ack=0, err=0 and busy=0, asynchronously.
REQ-026 Reset asserted in WAIT SHALL abort the access with no array write and no ack.
REQ-027 Array contents SHALL NOT be altered by reset.
REQ-028 The array SHALL power up with the package boot image when DEPTH=16 and DATA_W=8, and with all zeros otherwise.

Structure
REQ-029 The shared package mem_pkg SHALL hold the state enum (IDLE/WAIT/RESP) and the constant BOOT_IMAGE (16 x 8-bit program words).
REQ-030 The storage array SHALL be a single sub-module, mem_array (synchronous single-port, write-enable, registered read), with the FSM/handshake in sync_memory.

Verification
REQ-031 The bench SHALL check this boot-image read: defaults, after reset, req=1 we=0 addr=0 at E0 -> ack=1 and rdata=8'h4C in the cycle after E2; busy=1 for 3 cycles.
REQ-032 The bench SHALL check this write/readback: write addr=5 wdata=8'hA5, then read addr=5 -> second ack returns rdata=8'hA5 with err=0.
REQ-033 The bench SHALL check out-of-range access: DEPTH=12, write addr=13 wdata=8'hFF -> ack with err=1; subsequent reads of addresses 0..11 SHALL be unchanged.
REQ-034 The bench SHALL check zero wait states: WAIT_STATES=0, read addr=10 -> ack in the cycle right after the request edge, rdata=8'h08, and busy high for 1 cycle.
REQ-035 The bench SHALL check request while busy: a second req (write addr=1 wdata=8'h00) held during WAIT -> ignored; a later read of addr 1 returns 8'h5A.
REQ-036 The bench SHALL check reset mid-operation: write addr=2 wdata=8'h33, rst pulsed during WAIT -> no ack and outputs at 0 immediately; a read of addr 2 then returns 8'h7A.
